// File: rtl/alu_mw_seq.sv
// Multi-word sequencer for a 16-bit combinational ALU.
// Chains carry between words, keeps sticky flags per command.
module alu_mw_seq #(
  parameter int WIDTH      = 16,
  parameter int NWORDS_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_words,
  input  logic             cmd_cin,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_last,
  input  logic             abort,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_f,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [5:0]       alu_status,
  output logic [5:0]       flags_q,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT
  } state_t;

  localparam logic [CNT_W-1:0] MAXW = CNT_W'(NWORDS_MAX);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_words;
  logic [CNT_W-1:0] w_norm;
  logic [CNT_W-1:0] w_last_idx;
  logic             r_carry;
  logic             r_zacc;
  logic             r_aflag;
  logic [3:0]       r_stat;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_last;
  logic             r_done;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [4:0]       r_alu_f;
  logic             r_alu_cin;
  logic [5:0]       r_flags;
  logic             w_cmd_go;

  assign w_last_idx = r_words - CNT_W'(1);
  assign w_cmd_go   = cmd_valid && !abort;

  // Word count: zero means one word, oversize clamps to the max
  always_comb begin
    w_norm = cmd_words;
    if (cmd_words == '0)
      w_norm = CNT_W'(1);
    else if (cmd_words > MAXW)
      w_norm = MAXW;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state; abort wins over every normal transition
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (cmd_valid) w_next = S_FETCH;
        S_FETCH: if (op_valid)  w_next = S_EXEC;
        S_EXEC:  w_next = S_OUT;
        S_OUT: begin
          if (res_ready)
            w_next = r_res_last ? S_IDLE : S_FETCH;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    cmd_ready = rst_n && (r_state == S_IDLE);
    op_ready  = (r_state == S_FETCH);
    res_valid = (r_state == S_OUT);
  end

  // Datapath: ALU input regs, carry chain, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_words    <= '0;
      r_carry    <= 1'b0;
      r_zacc     <= 1'b0;
      r_aflag    <= 1'b0;
      r_stat     <= '0;
      r_res_data <= '0;
      r_res_last <= 1'b0;
      r_done     <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_f    <= '0;
      r_alu_cin  <= 1'b0;
      r_flags    <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_res_last <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_cmd_go) begin
              r_alu_f <= cmd_op;
              r_carry <= cmd_cin;
              r_words <= w_norm;
              r_idx   <= '0;
              r_zacc  <= 1'b1;
            end
          end
          S_FETCH: begin
            if (op_valid) begin
              r_alu_a   <= op_a;
              r_alu_b   <= op_b;
              r_alu_cin <= r_carry;
            end
          end
          S_EXEC: begin
            r_res_data <= alu_result;
            r_carry    <= alu_status[5];
            r_zacc     <= r_zacc & alu_status[4];
            r_stat     <= {alu_status[5], alu_status[3:1]};
            if (r_idx == '0)
              r_aflag <= alu_status[0];
            r_res_last <= (r_idx == w_last_idx);
          end
          S_OUT: begin
            if (res_ready) begin
              if (r_res_last) begin
                r_flags <= {r_stat[3], r_zacc, r_stat[2:0],
                            r_aflag};
                r_done     <= 1'b1;
                r_res_last <= 1'b0;
              end else begin
                r_idx <= r_idx + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign res_data = r_res_data;
  assign res_last = r_res_last;
  assign done     = r_done;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_f    = r_alu_f;
  assign alu_cin  = r_alu_cin;
  assign flags_q  = r_flags;

endmodule
